mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
// - Shares one memory bus between NREQ pipeline requesters: the fetch port and the load/store port.
// - Sits between the core's ibus/dbus ports and the single downstream memory bus.
// - Holds a grant for a whole burst, then returns the bus for re-arbitration.
// - Requesters see "not ready" while waiting; this drives the imem_wait/dmem_wait stall inputs.
// PARAMETERS
// - NREQ    2   number of requesters; index 0 = fetch, index NREQ-1 = load/store
// - ADDR_W  64  address width
// - DATA_W  64  data width; strobe width is DATA_W/8
// - LEN_W   4   burst length field width; beats = req_len+1
// PORTS
// - clk          in   1              clock
// - reset        in   1              synchronous, active-high reset
// - req_valid    in   NREQ           request valid; held stable until the last beat completes
// - req_write    in   NREQ           1 = write burst
// - req_addr     in   NREQ*ADDR_W    start address, flattened, requester i at [i*ADDR_W +: ADDR_W]
// - req_len      in   NREQ*LEN_W     beats-1 per requester
// - req_wdata    in   NREQ*DATA_W    write data of the current beat
// - req_strobe   in   NREQ*DATA_W/8  byte enables of the current beat
// - resp_ready   out  NREQ           beat accepted/returned, one-hot or zero
// - resp_last    out  NREQ           final beat of the burst
// - resp_rdata   out  DATA_W         read data, shared by all requesters; qualify with resp_ready
// - bus_valid    out  1              downstream request valid
// - bus_write    out  1              downstream write
// - bus_addr     out  ADDR_W         downstream address
// - bus_len      out  LEN_W          downstream beats-1
// - bus_wdata    out  DATA_W         downstream write data
// - bus_strobe   out  DATA_W/8       downstream byte enables
// - bus_ready    in   1              downstream beat handshake
// - bus_last     in   1              downstream final beat
// - bus_rdata    in   DATA_W         downstream read data
// BEHAVIOUR
// - Reset: state IDLE, grant 0, rr_ptr 0; all outputs 0, so bus_valid=0 and resp_ready=0.
// - FSM IDLE: if any req_valid, register the winner into grant and go to BUSY. No bus_valid in IDLE.
// - FSM BUSY, pass-through: bus_* = req_*[grant] combinationally, and bus_valid = req_valid[grant].
// - FSM BUSY, response routing: resp_ready[grant] = bus_ready and resp_last[grant] = bus_last; other bits stay 0.
// - FSM BUSY -> IDLE when bus_ready && bus_last.
// - FSM BUSY -> IDLE also when req_valid[grant]=0 (abort). bus_valid drops in the same cycle.
// - Latency: request first seen at cycle t in IDLE -> bus_valid at t+1. Best-case burst = 1 + beats cycles.
// - Completion: always one IDLE bubble cycle after a completion before the next grant, even if requests are pending.
// - Grant changes only on the IDLE->BUSY transition, never mid-burst.
// - Default priority: fixed, highest index wins, so load/store beats fetch.
// - Simultaneous new requests while BUSY: they wait. resp_ready stays 0 for the waiting requester.
// - Reset mid-burst: next cycle IDLE, bus_valid=0. The downstream slave must tolerate the abandoned burst.
// - bus_last without bus_ready is ignored.
// CONFIGURATION
// - ARB_ROUND_ROBIN_EN defined:
//   - rr_ptr (clog2(NREQ) bits) = index of the last granted requester.
//   - Search starts at rr_ptr+1, wrapping modulo NREQ; the first valid requester wins.
//   - rr_ptr updates on each IDLE->BUSY transition.
// - ARB_ROUND_ROBIN_EN undefined: fixed priority as above; rr_ptr is not instantiated.
// TESTING
// - Single fetch: req_valid=01, len=0, addr=0x8000_0000.
//   -> bus_valid at t+1 with bus_addr=0x8000_0000.
//   -> resp_ready=01 and resp_last=01 in the bus_ready&&bus_last cycle; IDLE the next cycle.
// - Contention, fixed priority: req_valid=11 at t -> grant=1, bus_addr = dmem addr.
//   -> fetch gets resp_ready=00 until the dmem burst ends.
//   -> fetch granted 2 cycles after dmem's last beat.
// - Burst: dmem len=3 read, bus_ready on 4 consecutive cycles, bus_last on the 4th.
//   -> 4 resp_ready pulses, resp_rdata mirrors bus_rdata, resp_last only on the 4th.
// - Abort: dmem drops req_valid mid-burst after beat 2.
//   -> bus_valid=0 in the same cycle, IDLE next cycle, pending fetch granted the cycle after.
// - Reset mid-burst: reset=1 while BUSY -> next cycle bus_valid=0 and resp_ready=00; no grant while reset holds.
// - With ARB_ROUND_ROBIN_EN, req_valid held at 11 with len=0 bursts.
//   -> grants alternate 1,0,1,0; without the macro -> grants stay 1,1,1,1.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-state burst arbiter sharing one downstream memory bus between NREQ requesters.
// Optional ARB_ROUND_ROBIN_EN selects round-robin arbitration; default is fixed priority (highest index wins).
module mem_bus_arbiter #(
   parameter int NREQ   = 2,
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter int LEN_W  = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NREQ-1:0]            req_valid,
   input  logic [NREQ-1:0]            req_write,
   input  logic [NREQ*ADDR_W-1:0]     req_addr,
   input  logic [NREQ*LEN_W-1:0]      req_len,
   input  logic [NREQ*DATA_W-1:0]     req_wdata,
   input  logic [NREQ*DATA_W/8-1:0]   req_strobe,
   output logic [NREQ-1:0]            resp_ready,
   output logic [NREQ-1:0]            resp_last,
   output logic [DATA_W-1:0]          resp_rdata,
   output logic                       bus_valid,
   output logic                       bus_write,
   output logic [ADDR_W-1:0]          bus_addr,
   output logic [LEN_W-1:0]           bus_len,
   output logic [DATA_W-1:0]          bus_wdata,
   output logic [DATA_W/8-1:0]        bus_strobe,
   input  logic                       bus_ready,
   input  logic                       bus_last,
   input  logic [DATA_W-1:0]          bus_rdata,
   output logic                       dbg_state_o
);

   localparam int STRB_W = DATA_W / 8;
   localparam int GNT_W  = (NREQ > 1) ? $clog2(NREQ) : 1;

   // Handshake: a beat moves when bus_valid && bus_ready; the burst ends on the
   // beat with bus_last, or early when the granted requester drops req_valid.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t             state_q;
   logic [GNT_W-1:0]   grant_q;
   logic [GNT_W-1:0]   winner_d;
   logic               busy;

   assign busy        = (state_q == ST_BUSY);
   assign dbg_state_o = state_q;

`ifdef ARB_ROUND_ROBIN_EN
   logic [GNT_W-1:0]   rr_ptr_q;

   // Scan from rr_ptr+1 upward with wrap; the lowest offset overwrites last and wins.
   always_comb begin
      int sum;
      logic [GNT_W-1:0] cand;
      winner_d = '0;
      sum      = 0;
      cand     = '0;
      for (int k = NREQ; k >= 1; k--) begin
         sum = int'(rr_ptr_q) + k;
         if (sum >= NREQ) sum = sum - NREQ;
         cand = GNT_W'(sum);
         if (req_valid[cand]) winner_d = cand;
      end
   end
`else
   always_comb begin
      winner_d = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (req_valid[i]) winner_d = GNT_W'(i);
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         grant_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         rr_ptr_q <= '0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (|req_valid) begin
                  grant_q  <= winner_d;
                  state_q  <= ST_BUSY;
`ifdef ARB_ROUND_ROBIN_EN
                  rr_ptr_q <= winner_d;
`endif
               end
            end
            ST_BUSY: begin
               if (!req_valid[grant_q] || (bus_ready && bus_last)) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Pass-through of the granted requester; everything is forced to zero while idle.
   always_comb begin
      bus_valid  = 1'b0;
      bus_write  = 1'b0;
      bus_addr   = '0;
      bus_len    = '0;
      bus_wdata  = '0;
      bus_strobe = '0;
      resp_ready = '0;
      resp_last  = '0;
      resp_rdata = '0;
      if (busy) begin
         bus_valid  = req_valid[grant_q];
         bus_write  = req_write[grant_q];
         bus_addr   = req_addr[grant_q*ADDR_W +: ADDR_W];
         bus_len    = req_len[grant_q*LEN_W +: LEN_W];
         bus_wdata  = req_wdata[grant_q*DATA_W +: DATA_W];
         bus_strobe = req_strobe[grant_q*STRB_W +: STRB_W];
         resp_ready[grant_q] = bus_ready;
         resp_last[grant_q]  = bus_last;
         resp_rdata = bus_rdata;
      end
   end

   a_resp_onehot: assert property (@(posedge clk) $onehot0(resp_ready));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (NREQ=2, 64-bit address/data).
// Expected values are hand-derived; the round-robin section follows ARB_ROUND_ROBIN_EN.
module tb_mem_bus_arbiter;

  localparam int NREQ = 2;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int LW = 4;
  localparam int SW = DW / 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_write;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*LW-1:0]   req_len;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [NREQ*SW-1:0]   req_strobe;
  logic [NREQ-1:0]      resp_ready;
  logic [NREQ-1:0]      resp_last;
  logic [DW-1:0]        resp_rdata;
  logic                 bus_valid;
  logic                 bus_write;
  logic [AW-1:0]        bus_addr;
  logic [LW-1:0]        bus_len;
  logic [DW-1:0]        bus_wdata;
  logic [SW-1:0]        bus_strobe;
  logic                 bus_ready;
  logic                 bus_last;
  logic [DW-1:0]        bus_rdata;
  logic                 dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  mem_bus_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_len(req_len), .req_wdata(req_wdata), .req_strobe(req_strobe),
    .resp_ready(resp_ready), .resp_last(resp_last), .resp_rdata(resp_rdata),
    .bus_valid(bus_valid), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_len(bus_len), .bus_wdata(bus_wdata), .bus_strobe(bus_strobe),
    .bus_ready(bus_ready), .bus_last(bus_last), .bus_rdata(bus_rdata),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // checking
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [LW-1:0] l, input logic [DW-1:0] d, input logic [SW-1:0] s);
    req_valid[i]          = v;
    req_write[i]          = w;
    req_addr[i*AW +: AW]  = a;
    req_len[i*LW +: LW]   = l;
    req_wdata[i*DW +: DW] = d;
    req_strobe[i*SW +: SW] = s;
  endtask

  task automatic set_bus(input logic r, input logic l, input logic [DW-1:0] d);
    bus_ready = r;
    bus_last  = l;
    bus_rdata = d;
  endtask

  initial begin
    logic [1:0] exp_g[4];

    reset = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_len = '0;
    req_wdata = '0; req_strobe = '0;
    set_bus(1'b0, 1'b0, '0);
    cyc(); cyc();
    check("reset_bus_valid", 64'(bus_valid), 64'h0);
    check("reset_resp_ready", 64'(resp_ready), 64'h0);
    check("reset_state", 64'(dbg_state), 64'h0);
    reset = 1'b0;

    // single fetch, len=0
    cyc();
    set_req(0, 1'b1, 1'b0, 64'h8000_0000, 4'd0, '0, '0);
    settle();
    check("fetch_idle_no_valid", 64'(bus_valid), 64'h0);
    cyc();
    check("fetch_bus_valid", 64'(bus_valid), 64'h1);
    check("fetch_bus_addr", bus_addr, 64'h8000_0000);
    check("fetch_bus_write", 64'(bus_write), 64'h0);
    set_bus(1'b1, 1'b1, 64'hCAFE_0001);
    settle();
    check("fetch_resp_ready", 64'(resp_ready), 64'h1);
    check("fetch_resp_last", 64'(resp_last), 64'h1);
    check("fetch_resp_rdata", resp_rdata, 64'hCAFE_0001);
    cyc();
    set_req(0, 1'b0, 1'b0, '0, '0, '0, '0);
    set_bus(1'b0, 1'b0, '0);
    settle();
    check("fetch_back_idle", 64'(dbg_state), 64'h0);
    check("fetch_idle_bus_valid", 64'(bus_valid), 64'h0);

    // contention: dmem (2-beat write) beats fetch
    set_req(0, 1'b1, 1'b0, 64'h2000, 4'd0, '0, '0);
    set_req(1, 1'b1, 1'b1, 64'h1000, 4'd1, 64'hDEAD_BEEF_0123_4567, 8'h0F);
    cyc();
    check("cont_grant_dmem_addr", bus_addr, 64'h1000);
    check("cont_bus_write", 64'(bus_write), 64'h1);
    check("cont_bus_len", 64'(bus_len), 64'h1);
    check("cont_bus_wdata", bus_wdata, 64'hDEAD_BEEF_0123_4567);
    check("cont_bus_strobe", 64'(bus_strobe), 64'h0F);
    check("cont_wait_resp", 64'(resp_ready), 64'h0);
    set_bus(1'b1, 1'b0, '0);
    settle();
    check("cont_beat1_ready", 64'(resp_ready), 64'h2);
    check("cont_beat1_last", 64'(resp_last), 64'h0);
    cyc();
    set_bus(1'b1, 1'b1, '0);
    settle();
    check("cont_beat2_ready", 64'(resp_ready), 64'h2);
    check("cont_beat2_last", 64'(resp_last), 64'h2);
    cyc();
    set_req(1, 1'b0, 1'b0, '0, '0, '0, '0);
    set_bus(1'b0, 1'b0, '0);
    settle();
    check("cont_bubble_state", 64'(dbg_state), 64'h0);
    check("cont_bubble_valid", 64'(bus_valid), 64'h0);
    check("cont_bubble_fetch_resp", 64'(resp_ready), 64'h0);
    cyc();
    check("cont_fetch_granted", 64'(bus_valid), 64'h1);
    check("cont_fetch_addr", bus_addr, 64'h2000);
    set_bus(1'b1, 1'b1, '0);
    settle();
    check("cont_fetch_resp", 64'(resp_ready), 64'h1);
    cyc();
    set_req(0, 1'b0, 1'b0, '0, '0, '0, '0);
    set_bus(1'b0, 1'b0, '0);

    // dmem 4-beat read burst; stray bus_last without bus_ready first
    set_req(1, 1'b1, 1'b0, 64'h3000, 4'd3, '0, '0);
    cyc();
    check("burst_addr", bus_addr, 64'h3000);
    check("burst_len", 64'(bus_len), 64'h3);
    set_bus(1'b0, 1'b1, '0);
    settle();
    check("burst_last_noready_resp", 64'(resp_ready), 64'h0);
    cyc();
    check("burst_last_noready_busy", 64'(dbg_state), 64'h1);
    for (int b = 1; b <= 4; b++) begin
      set_bus(1'b1, (b == 4), 64'(b) * 64'h1111);
      settle();
      check("burst_resp_ready", 64'(resp_ready), 64'h2);
      check("burst_resp_rdata", resp_rdata, 64'(b) * 64'h1111);
      check("burst_resp_last", 64'(resp_last), (b == 4) ? 64'h2 : 64'h0);
      cyc();
    end
    set_req(1, 1'b0, 1'b0, '0, '0, '0, '0);
    set_bus(1'b0, 1'b0, '0);
    settle();
    check("burst_end_idle", 64'(dbg_state), 64'h0);

    // abort after beat 2 with fetch pending
    set_req(1, 1'b1, 1'b0, 64'h4000, 4'd3, '0, '0);
    cyc();
    set_req(0, 1'b1, 1'b0, 64'h5000, 4'd0, '0, '0);
    set_bus(1'b1, 1'b0, 64'h77);
    settle();
    check("abort_dmem_granted", bus_addr, 64'h4000);
    check("abort_beat1", 64'(resp_ready), 64'h2);
    cyc();
    settle();
    check("abort_beat2", 64'(resp_ready), 64'h2);
    cyc();
    set_req(1, 1'b0, 1'b0, '0, '0, '0, '0);
    set_bus(1'b0, 1'b0, '0);
    settle();
    check("abort_valid_drop", 64'(bus_valid), 64'h0);
    check("abort_fetch_wait", 64'(resp_ready), 64'h0);
    cyc();
    check("abort_idle", 64'(dbg_state), 64'h0);
    cyc();
    check("abort_fetch_granted", 64'(bus_valid), 64'h1);
    check("abort_fetch_addr", bus_addr, 64'h5000);
    set_bus(1'b1, 1'b1, '0);
    cyc();
    set_req(0, 1'b0, 1'b0, '0, '0, '0, '0);
    set_bus(1'b0, 1'b0, '0);

    // reset mid-burst
    set_req(1, 1'b1, 1'b0, 64'h6000, 4'd3, '0, '0);
    cyc();
    check("rst_mid_busy", 64'(bus_valid), 64'h1);
    reset = 1'b1;
    set_bus(1'b1, 1'b0, '0);
    cyc();
    check("rst_mid_valid", 64'(bus_valid), 64'h0);
    check("rst_mid_resp", 64'(resp_ready), 64'h0);
    check("rst_mid_state", 64'(dbg_state), 64'h0);
    cyc();
    check("rst_hold_no_grant", 64'(dbg_state), 64'h0);
    check("rst_hold_valid", 64'(bus_valid), 64'h0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0, '0);
    set_bus(1'b0, 1'b0, '0);
    reset = 1'b0;
    cyc();

    // both requesting continuously, single-beat bursts
`ifdef ARB_ROUND_ROBIN_EN
    exp_g[0] = 2'd1; exp_g[1] = 2'd0; exp_g[2] = 2'd1; exp_g[3] = 2'd0;
`else
    exp_g[0] = 2'd1; exp_g[1] = 2'd1; exp_g[2] = 2'd1; exp_g[3] = 2'd1;
`endif
    set_req(0, 1'b1, 1'b0, 64'h100, 4'd0, '0, '0);
    set_req(1, 1'b1, 1'b0, 64'h200, 4'd0, '0, '0);
    set_bus(1'b1, 1'b1, '0);
    for (int g = 0; g < 4; g++) begin
      cyc();
      check("arb_order_addr", bus_addr, (exp_g[g] == 2'd1) ? 64'h200 : 64'h100);
      check("arb_order_resp", 64'(resp_ready), (exp_g[g] == 2'd1) ? 64'h2 : 64'h1);
      cyc();
    end
    req_valid = '0;
    set_bus(1'b0, 1'b0, '0);
    cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
